irq_source_ctrl: RTL and testbench

Peripheral-side interrupt controller that drives the core's single `interrupter` input and consumes the core's interrupt-accept and force-jump outputs. It edge-detects up to `N_SRC` peripheral request lines, latches them as pending, and applies a software mask. It raises one request to the core, records which source was taken when the core accepts, and holds off further requests until the handler returns (ERET). The handler reads and controls it through a small register port on the data-memory side.

---
 rtl/irq_source_ctrl.sv | 155 +++++++++++++++
 tb/tb_irq_source_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_source_ctrl.sv
// Purpose: edge-detecting, maskable, fixed-priority interrupt source controller for one core interrupt line.
// Latency: source edge to interrupter 2 cycles; register read data 1 cycle after reg_ren.
// Backpressure: none; requests stay pending until acked or cleared, and one request is held off until ERET.
module irq_source_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  output logic             interrupter,
  input  logic             ir,
  input  logic             jump_en,
  input  logic             reg_ren,
  input  logic             reg_wen,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_din,
  output logic [31:0]      reg_dout,
  output logic             busy
);

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_CLEAR   = 2'd2;
  localparam logic [1:0] ADDR_CAUSE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   prev_q, prev_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic               cause_vld_q, cause_vld_d;
  logic [3:0]         cause_id_q, cause_id_d;
  logic [31:0]        dout_q, dout_d;
  logic               irq_q, irq_d;
  logic               busy_q, busy_d;

  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   clr;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   lowest;
  logic [N_SRC-1:0]   ack_bit;
  logic [3:0]         sel;
  logic [31:0]        cause_word;
  logic [31:0]        pending_word;
  logic [31:0]        mask_word;

  assign interrupter = irq_q;
  assign busy        = busy_q;
  assign reg_dout    = dout_q;

  // Priority pick: lowest-index eligible source, both as an index and one-hot.
  always_comb begin
    eligible = pending_q & mask_q;
    sel      = 4'd0;
    lowest   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel       = 4'(i);
        lowest    = '0;
        lowest[i] = 1'b1;
      end
    end
  end

  // Request FSM: raise, take on ir, hold off until ERET, withdraw if nothing is eligible.
  always_comb begin
    state_d     = state_q;
    ack_bit     = '0;
    cause_vld_d = cause_vld_q;
    cause_id_d  = cause_id_q;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (ir) begin
          // ack_bit is empty if the source vanished the same cycle the core took it.
          state_d     = ST_SERVICE;
          cause_vld_d = 1'b1;
          cause_id_d  = sel;
          ack_bit     = lowest;
        end else if (!(|eligible)) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (jump_en && !ir) begin
          state_d     = ST_IDLE;
          cause_vld_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    irq_d  = (state_d == ST_REQ);
    busy_d = (state_d == ST_SERVICE);
  end

  // Edge detect, pending set/clear, mask write and registered read mux.
  always_comb begin
    prev_d = irq_src;
    rise   = irq_src & ~prev_q;
    clr    = '0;
    mask_d = mask_q;
    if (reg_wen && reg_addr == ADDR_CLEAR) clr    = reg_din[N_SRC-1:0];
    if (reg_wen && reg_addr == ADDR_MASK)  mask_d = reg_din[N_SRC-1:0];
    // A new edge wins over a clear or an ack on the same bit.
    pending_d = (pending_q & ~clr & ~ack_bit) | rise;

    pending_word = 32'(pending_q);
    mask_word    = 32'(mask_q);
    cause_word   = {cause_vld_q, 27'd0, cause_id_q};

    // Reads see pre-edge state, so a same-cycle MASK write returns the old mask.
    dout_d = dout_q;
    if (reg_ren) begin
      case (reg_addr)
        ADDR_PENDING: dout_d = pending_word;
        ADDR_MASK:    dout_d = mask_word;
        ADDR_CAUSE:   dout_d = cause_word;
        default:      dout_d = 32'd0;
      endcase
    end
  end

  // State registers; reset clears everything immediately and drops any request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      cause_vld_q <= 1'b0;
      cause_id_q  <= 4'd0;
      dout_q      <= 32'd0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      cause_vld_q <= cause_vld_d;
      cause_id_q  <= cause_id_d;
      dout_q      <= dout_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_irq_source_ctrl.sv
module tb_irq_source_ctrl;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_src;
  logic          interrupter;
  logic          ir;
  logic          jump_en;
  logic          reg_ren;
  logic          reg_wen;
  logic [1:0]    reg_addr;
  logic [31:0]   reg_din;
  logic [31:0]   reg_dout;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  irq_source_ctrl #(.N_SRC(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .interrupter(interrupter),
    .ir         (ir),
    .jump_en    (jump_en),
    .reg_ren    (reg_ren),
    .reg_wen    (reg_wen),
    .reg_addr   (reg_addr),
    .reg_din    (reg_din),
    .reg_dout   (reg_dout),
    .busy       (busy)
  );

  // Reference model: pending/mask as bit sets, "requesting" and "servicing" flags.
  logic [N-1:0] m_prev, m_pend, m_mask;
  bit           m_cvld;
  int           m_cid;
  logic [31:0]  m_dout;
  bit           m_req, m_svc;

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_mask = '0;
    m_cvld = 0;  m_cid = 0;   m_dout = '0;
    m_req  = 0;  m_svc = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] rise, elig, clr, ack;
    int sel;
    rise = irq_src & ~m_prev;
    elig = m_pend & m_mask;
    sel  = -1;
    for (int i = 0; i < N; i++) if (elig[i] && sel < 0) sel = i;
    clr = '0;
    ack = '0;
    if (reg_wen && reg_addr == 2'd2) clr = reg_din[N-1:0];
    if (reg_ren) begin
      if (reg_addr == 2'd0)      m_dout = 32'(m_pend);
      else if (reg_addr == 2'd1) m_dout = 32'(m_mask);
      else if (reg_addr == 2'd3) m_dout = (m_cvld ? 32'h8000_0000 : 32'h0) | 32'(m_cid);
      else                       m_dout = 32'h0;
    end
    if (m_req) begin
      if (ir) begin
        m_req  = 0;
        m_svc  = 1;
        m_cvld = 1;
        m_cid  = (sel < 0) ? 0 : sel;
        if (sel >= 0) ack[sel] = 1'b1;
      end else if (sel < 0) begin
        m_req = 0;
      end
    end else if (m_svc) begin
      if (jump_en && !ir) begin
        m_svc  = 0;
        m_cvld = 0;
      end
    end else if (sel >= 0) begin
      m_req = 1;
    end
    m_pend = (m_pend & ~clr & ~ack) | rise;
    if (reg_wen && reg_addr == 2'd1) m_mask = reg_din[N-1:0];
    m_prev = irq_src;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the edge, DUT outputs compared 1ns later.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step();
    #1;
    chk("interrupter", 32'(interrupter), 32'(m_req));
    chk("busy",        32'(busy),        32'(m_svc));
    chk("reg_dout",    reg_dout,         m_dout);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_wen = 1'b1; reg_addr = a; reg_din = d;
    tick();
    reg_wen = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_ren = 1'b1; reg_addr = a;
    tick();
    reg_ren = 1'b0;
    d = reg_dout;
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b0; irq_src = '0; ir = 1'b0; jump_en = 1'b0;
    reg_ren = 1'b0; reg_wen = 1'b0; reg_addr = 2'd0; reg_din = '0;
    model_reset();
    tick(); tick();
    rst = 1'b1;
    chk("reset_irq",  32'(interrupter), 32'd0);
    chk("reset_busy", 32'(busy),        32'd0);
    chk("reset_dout", reg_dout,         32'd0);

    // Single source on bit 2.
    wr(2'd1, 32'h04);
    irq_src[2] = 1'b1;
    tick();
    chk("single_k",   32'(interrupter), 32'd0);
    irq_src[2] = 1'b0;
    tick();
    chk("single_k1",  32'(interrupter), 32'd1);
    ir = 1'b1; tick(); ir = 1'b0;
    chk("single_ack_irq",  32'(interrupter), 32'd0);
    chk("single_ack_busy", 32'(busy),        32'd1);
    rd(2'd3, v); chk("single_cause", v, 32'h8000_0002);
    rd(2'd0, v); chk("single_pend",  v, 32'h0);
    jump_en = 1'b1; tick(); jump_en = 1'b0;
    chk("single_eret_busy", 32'(busy), 32'd0);
    rd(2'd3, v); chk("single_cause_eret", v, 32'h0000_0002);

    // Priority between sources 5 and 1, hold-off during service.
    wr(2'd1, 32'hFF);
    irq_src = 8'h22; tick(); irq_src = '0; tick();
    chk("prio_req", 32'(interrupter), 32'd1);
    ir = 1'b1; tick(); ir = 1'b0;
    rd(2'd3, v); chk("prio_cause1", v, 32'h8000_0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("prio_holdoff", 32'(interrupter), 32'd0);
    end
    jump_en = 1'b1; tick(); jump_en = 1'b0;
    chk("prio_eret_idle", 32'(interrupter), 32'd0);
    tick();
    chk("prio_rereq", 32'(interrupter), 32'd1);
    ir = 1'b1; tick(); ir = 1'b0;
    rd(2'd3, v); chk("prio_cause5", v, 32'h8000_0005);
    jump_en = 1'b1; tick(); jump_en = 1'b0;

    // Masked source becomes eligible once unmasked.
    wr(2'd1, 32'h0);
    irq_src[3] = 1'b1; tick(); irq_src[3] = 1'b0; tick(); tick();
    chk("masked_noreq", 32'(interrupter), 32'd0);
    rd(2'd0, v); chk("masked_pend", v, 32'h08);
    wr(2'd1, 32'h08);
    chk("unmask_w", 32'(interrupter), 32'd0);
    tick();
    chk("unmask_w1", 32'(interrupter), 32'd1);
    ir = 1'b1; tick(); ir = 1'b0;
    jump_en = 1'b1; tick(); jump_en = 1'b0;

    // Withdraw by CLEAR while requesting.
    wr(2'd1, 32'h10);
    irq_src[4] = 1'b1; tick(); irq_src[4] = 1'b0; tick();
    chk("wd_req", 32'(interrupter), 32'd1);
    wr(2'd2, 32'h10);
    chk("wd_w", 32'(interrupter), 32'd1);
    tick();
    chk("wd_w1", 32'(interrupter), 32'd0);
    ir = 1'b1; tick(); ir = 1'b0;
    chk("wd_ir_ignored", 32'(busy), 32'd0);
    rd(2'd3, v); chk("wd_cause_invalid", 32'(v[31]), 32'd0);

    // Edge and CLEAR on the same bit in the same cycle: set wins.
    irq_src[0] = 1'b1;
    wr(2'd2, 32'h01);
    irq_src[0] = 1'b0;
    rd(2'd0, v); chk("setclr_pend", v, 32'h01);

    // Asynchronous reset in the middle of a request.
    wr(2'd1, 32'h01);
    tick();
    chk("rst_pre_req", 32'(interrupter), 32'd1);
    rd(2'd1, v); chk("rst_pre_dout", v, 32'h01);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_irq",  32'(interrupter), 32'd0);
    chk("rst_async_busy", 32'(busy),        32'd0);
    chk("rst_async_dout", reg_dout,         32'd0);
    model_reset();
    #1 rst = 1'b1;
    tick();
    rd(2'd0, v); chk("rst_pend", v, 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      irq_src  = irq_src ^ N'($urandom & $urandom & $urandom);
      ir       = ($urandom_range(0, 3) == 0);
      jump_en  = ($urandom_range(0, 4) == 0);
      reg_ren  = ($urandom_range(0, 2) == 0);
      reg_wen  = ($urandom_range(0, 3) == 0);
      reg_addr = 2'($urandom_range(0, 3));
      reg_din  = $urandom;
      tick();
    end
    ir = 1'b0; jump_en = 1'b0; reg_ren = 1'b0; reg_wen = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
